// File: rtl/cache_mem_arbiter.sv
// Shares one memory bus between I-cache reads and D-cache reads/writebacks, one whole line per grant.
// Optional macro ARB_ROUND_ROBIN_EN: alternate simultaneous requests; otherwise the D-cache wins ties.
module cache_mem_arbiter #(
  parameter int WORDSIZE = 64,
  parameter int BEATS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_reqcyc,
  input  logic [WORDSIZE-1:0] i_req,
  output logic                i_reqack,
  output logic                i_respcyc,
  input  logic                i_respack,
  input  logic                d_reqcyc,
  input  logic [WORDSIZE-1:0] d_req,
  input  logic                d_we,
  output logic                d_reqack,
  output logic                d_respcyc,
  input  logic                d_respack,
  output logic [WORDSIZE-1:0] resp,
  output logic                m_reqcyc,
  output logic [WORDSIZE-1:0] m_req,
  output logic                m_we,
  input  logic                m_reqack,
  input  logic                m_respcyc,
  input  logic [WORDSIZE-1:0] m_resp,
  output logic                m_respack
);
  localparam int CW = $clog2(BEATS + 2);
  localparam logic [CW-1:0] LAST = CW'(BEATS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          own_reqcyc, own_respack, req_fire, resp_fire, pick_d, txn_done;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
  // On a tie the requester that did not win last time gets the bus.
  assign pick_d = d_reqcyc && (!i_reqcyc || !last_grant_q);
`else
  assign pick_d = d_reqcyc;
`endif

  assign own_reqcyc  = owner_q ? d_reqcyc  : i_reqcyc;
  assign own_respack = owner_q ? d_respack : i_respack;
  assign req_fire    = (state_q == S_REQ)  && own_reqcyc && m_reqack;
  assign resp_fire   = (state_q == S_RESP) && m_respcyc  && own_respack;
  // cnt_q counts beats already moved this grant (address included), so the beat seen at LAST closes it.
  assign txn_done    = (cnt_q == LAST) && (resp_fire || (req_fire && we_q));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
    if (txn_done) last_grant_d = owner_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_reqcyc || d_reqcyc) begin
          state_d = S_REQ;
          owner_d = pick_d;
          we_d    = pick_d && d_we;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (req_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (!we_q)         state_d = S_RESP;
          else if (txn_done) state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (resp_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (txn_done) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign resp = m_resp;

  always_comb begin
    i_reqack  = 1'b0;
    i_respcyc = 1'b0;
    d_reqack  = 1'b0;
    d_respcyc = 1'b0;
    m_reqcyc  = 1'b0;
    m_req     = '0;
    m_we      = 1'b0;
    m_respack = 1'b0;
    unique case (state_q)
      S_REQ: begin
        m_reqcyc = own_reqcyc;
        m_req    = owner_q ? d_req : i_req;
        m_we     = we_q;
        if (owner_q) d_reqack = m_reqack;
        else         i_reqack = m_reqack;
      end
      S_RESP: begin
        m_respack = own_respack;
        if (owner_q) d_respcyc = m_respcyc;
        else         i_respcyc = m_respcyc;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: vector table, directed line transfers, then random traffic vs a beat-count model.
module tb_cache_mem_arbiter;
  localparam int W = 64;
  localparam int BEATS = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_reqcyc, i_reqack, i_respcyc, i_respack;
  logic         d_reqcyc, d_we, d_reqack, d_respcyc, d_respack;
  logic         m_reqcyc, m_we, m_reqack, m_respcyc, m_respack;
  logic [W-1:0] i_req, d_req, resp, m_req, m_resp;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.WORDSIZE(W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqack(i_reqack), .i_respcyc(i_respcyc), .i_respack(i_respack),
    .d_reqcyc(d_reqcyc), .d_req(d_req), .d_we(d_we), .d_reqack(d_reqack), .d_respcyc(d_respcyc),
    .d_respack(d_respack), .resp(resp),
    .m_reqcyc(m_reqcyc), .m_req(m_req), .m_we(m_we), .m_reqack(m_reqack), .m_respcyc(m_respcyc),
    .m_resp(m_resp), .m_respack(m_respack)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: who holds the bus and how many beats of each kind have moved.
  logic mb_busy = 1'b0, mb_owner = 1'b0, mb_we = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
  logic mb_last = 1'b1;
`endif
  int   mb_nreq = 0, mb_nresp = 0;
  logic e_reqph, e_ira, e_irc, e_dra, e_drc, e_mrc, e_mra, m_own_cyc, m_own_ack;

  task automatic model_eval();
    m_own_cyc = mb_owner ? d_reqcyc : i_reqcyc;
    m_own_ack = mb_owner ? d_respack : i_respack;
    e_reqph   = mb_busy && (mb_nreq < (mb_we ? BEATS + 1 : 1));
    {e_ira, e_irc, e_dra, e_drc, e_mrc, e_mra} = '0;
    if (e_reqph) begin
      e_mrc = m_own_cyc;
      if (mb_owner) e_dra = m_reqack; else e_ira = m_reqack;
    end else if (mb_busy) begin
      e_mra = m_own_ack;
      if (mb_owner) e_drc = m_respcyc; else e_irc = m_respcyc;
    end
  endtask

  task automatic model_update();
    if (reset) begin
      mb_busy = 1'b0; mb_owner = 1'b0; mb_we = 1'b0; mb_nreq = 0; mb_nresp = 0;
`ifdef ARB_ROUND_ROBIN_EN
      mb_last = 1'b1;
`endif
    end else if (!mb_busy) begin
      if (i_reqcyc || d_reqcyc) begin
`ifdef ARB_ROUND_ROBIN_EN
        mb_owner = (i_reqcyc && d_reqcyc) ? !mb_last : d_reqcyc;
`else
        mb_owner = d_reqcyc;
`endif
        mb_we = mb_owner && d_we;
        mb_busy = 1'b1; mb_nreq = 0; mb_nresp = 0;
      end
    end else if (e_reqph) begin
      if (m_own_cyc && m_reqack) begin
        mb_nreq++;
        if (mb_we && mb_nreq == BEATS + 1) begin
          mb_busy = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          mb_last = mb_owner;
`endif
        end
      end
    end else if (m_respcyc && m_own_ack) begin
      mb_nresp++;
      if (mb_nresp == BEATS) begin
        mb_busy = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        mb_last = mb_owner;
`endif
      end
    end
  endtask

  // Traffic engine: the caches and memory as simple agents with beat counts.
  int   i_pend = 0, i_wait = 0, d_pend = 0, d_wait = 0, d_sent = 0;
  logic d_we_r = 1'b0;
  logic [W-1:0] i_addr = '0, d_addr = '0, d_base = '0, resp_base = '0;
  int   p_new_i = 0, p_new_d = 0, p_dwe = 0, p_mack = 100, p_mresp = 100, p_iack = 100, p_dack = 100, p_rst = 0;
  bit   rnd_data = 1'b0, rst_now = 1'b0;
  int   mresp_k = 0, stall_at = -1, stall_left = 0, d_resp_seen = 0;
  logic [W-1:0] i_got[$], mreq_got[$];
  int   grant_log[$];

  function automatic bit roll(input int p);
    return $urandom_range(99) < p;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic start_i(input logic [W-1:0] a);
    i_addr = a; i_pend = 1; i_wait = BEATS;
  endtask

  task automatic start_d(input logic we, input logic [W-1:0] a, input logic [W-1:0] base);
    d_we_r = we; d_addr = a; d_base = base; d_sent = 0;
    d_pend = we ? BEATS + 1 : 1;
    d_wait = we ? 0 : BEATS;
  endtask

  task automatic drive();
    if (i_pend == 0 && i_wait == 0 && roll(p_new_i)) start_i(rnd_data ? rnd64() : i_addr);
    if (d_pend == 0 && d_wait == 0 && roll(p_new_d))
      start_d(roll(p_dwe), rnd_data ? rnd64() : d_addr, rnd_data ? rnd64() : d_base);
    reset     = rst_now || roll(p_rst);
    i_reqcyc  = i_pend > 0;
    i_req     = i_addr;
    d_reqcyc  = d_pend > 0;
    d_we      = d_we_r;
    d_req     = (d_sent == 0) ? d_addr : d_base + W'(d_sent - 1);
    m_reqack  = roll(p_mack);
    m_respcyc = roll(p_mresp);
    i_respack = roll(p_iack);
    d_respack = roll(p_dack);
    if (stall_left > 0 && i_got.size() == stall_at) begin
      i_respack = 1'b0;
      stall_left--;
    end
    m_resp = rnd_data ? rnd64() : resp_base + W'(mresp_k);
  endtask

  task automatic cycle(input string nm);
    drive();
    #4;
    model_eval();
    chk(nm, 64'({i_reqack, i_respcyc, d_reqack, d_respcyc, m_reqcyc, m_respack}),
            64'({e_ira, e_irc, e_dra, e_drc, e_mrc, e_mra}));
    chk({nm, " resp"}, resp, m_resp);
    if (e_reqph) begin
      chk({nm, " m_req"}, m_req, mb_owner ? d_req : i_req);
      chk({nm, " m_we"}, 64'(m_we), 64'(mb_we));
    end
    if (reset) begin
      i_pend = 0; i_wait = 0; d_pend = 0; d_wait = 0;
    end else begin
      if (e_mrc && m_reqack) mreq_got.push_back(m_req);
      if (i_reqcyc && e_ira) begin grant_log.push_back(0); i_pend--; end
      if (d_reqcyc && e_dra) begin
        if (d_sent == 0) grant_log.push_back(1);
        d_sent++; d_pend--;
      end
      if (e_irc && i_respack) begin i_got.push_back(resp); i_wait--; end
      if (e_drc && d_respack) d_wait--;
      if (e_mra && m_respcyc) mresp_k++;
    end
    if (d_respcyc) d_resp_seen++;
    model_update();
    @(posedge clk); #1;
  endtask

  task automatic run_done(input string nm, input int max);
    int n = 0;
    while ((i_pend != 0 || i_wait != 0 || d_pend != 0 || d_wait != 0 || mb_busy) && n < max) begin
      cycle(nm);
      n++;
    end
    chk({nm, " finished in budget"}, 64'(n < max), 64'(1));
  endtask

  task automatic chk_iline(input string nm, input logic [W-1:0] base);
    chk({nm, " beats"}, 64'(i_got.size()), 64'(BEATS));
    for (int k = 0; k < BEATS; k++)
      chk($sformatf("%s data%0d", nm, k), (k < i_got.size()) ? i_got[k] : '1, base + W'(k));
  endtask

  // Table of per-cycle control vectors:
  // in  = {reset, i_reqcyc, d_reqcyc, d_we, m_reqack, m_respcyc, i_respack, d_respack}
  // exp = {i_reqack, i_respcyc, d_reqack, d_respcyc, m_reqcyc, m_respack}
  typedef struct packed {
    logic [7:0] in;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [7:0] in, input logic [5:0] exp, input int n);
    vec_t v;
    v.in = in; v.exp = exp;
    repeat (n) tbl.push_back(v);
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  int exp_order[4] = '{0, 1, 0, 1};
`else
  int exp_order[4] = '{1, 1, 1, 1};
`endif

  initial begin
    reset = 1'b1;
    {i_reqcyc, i_respack, d_reqcyc, d_we, d_respack, m_reqack, m_respcyc} = '0;
    i_req = '0; d_req = '0; m_resp = '0;
    repeat (2) @(posedge clk);
    #1;
    model_update();

    add(8'b1000_0000, 6'b000000, 1);  // reset state
    add(8'b0100_0000, 6'b000000, 1);  // arbitration takes a cycle
    add(8'b0100_0000, 6'b000010, 1);  // I owns, memory not ready
    add(8'b0100_1000, 6'b100010, 1);  // address accepted
    add(8'b0000_0110, 6'b010001, 1);  // resp beat 1
    add(8'b0010_0010, 6'b000001, 1);  // no beat; D now waiting
    add(8'b0010_0100, 6'b010000, 1);  // I stalls, beat not taken
    add(8'b0010_0110, 6'b010001, 7);  // beats 2..8
    add(8'b0010_0110, 6'b000000, 1);  // idle, D arbitrates
    add(8'b0010_1000, 6'b001010, 1);  // D read address
    add(8'b0000_0111, 6'b000101, 8);  // D beats, I respack ignored
    add(8'b0000_0111, 6'b000000, 1);
    add(8'b0011_0000, 6'b000000, 1);  // D writeback request
    add(8'b0011_1100, 6'b001010, 1);  // address; m_respcyc ignored
    add(8'b0010_1100, 6'b001010, 8);  // data beats
    add(8'b0000_0100, 6'b000000, 1);  // back to idle
    for (int k = 0; k < tbl.size(); k++) begin
      {reset, i_reqcyc, d_reqcyc, d_we, m_reqack, m_respcyc, i_respack, d_respack} = tbl[k].in;
      #4;
      model_eval();
      chk($sformatf("tbl[%0d]", k), 64'({i_reqack, i_respcyc, d_reqack, d_respcyc, m_reqcyc, m_respack}),
          64'(tbl[k].exp));
      model_update();
      @(posedge clk); #1;
    end

    // I read alone, data 0x10..0x17
    i_got.delete(); mreq_got.delete(); resp_base = 64'h10; mresp_k = 0;
    start_i(64'h400);
    run_done("iread", 60);
    chk_iline("iread", 64'h10);
    chk("iread addr", (mreq_got.size() > 0) ? mreq_got[0] : '1, 64'h400);

    // D writeback: address then 8 data beats in order, never a response
    mreq_got.delete(); d_resp_seen = 0;
    start_d(1'b1, 64'h1000, 64'hA0);
    run_done("dwb", 60);
    chk("dwb beats", 64'(mreq_got.size()), 64'(BEATS + 1));
    for (int k = 0; k <= BEATS; k++)
      chk($sformatf("dwb beat%0d", k), (k < mreq_got.size()) ? mreq_got[k] : '1,
          (k == 0) ? 64'h1000 : 64'hA0 + W'(k - 1));
    chk("dwb no respcyc", 64'(d_resp_seen), 64'(0));

    // Both caches keep requesting reads
    reset = 1'b1; #4; model_update(); @(posedge clk); #1;
    grant_log.delete(); p_new_i = 100; p_new_d = 100; p_dwe = 0;
    for (int n = 0; n < 200 && grant_log.size() < 4; n++) cycle("tie");
    p_new_i = 0; p_new_d = 0;
    run_done("tie drain", 100);
    for (int k = 0; k < 4; k++)
      chk($sformatf("tie grant%0d", k), (k < grant_log.size()) ? 64'(grant_log[k]) : '1, 64'(exp_order[k]));

    // D arrives while I is receiving its line
    grant_log.delete(); i_got.delete(); mresp_k = 0;
    start_i(64'h480);
    for (int n = 0; n < 30 && i_got.size() < 1; n++) cycle("dwait pre");
    start_d(1'b0, 64'h2000, '0);
    run_done("dwait", 80);
    chk("dwait grants", 64'(grant_log.size()), 64'(2));
    chk("dwait order", (grant_log.size() == 2) ? 64'({grant_log[0][0], grant_log[1][0]}) : '1, 64'(2'b01));

    // I holds off three beats mid-burst
    i_got.delete(); mresp_k = 0; stall_at = 3; stall_left = 3;
    start_i(64'h500);
    run_done("stall", 60);
    chk("stall applied", 64'(stall_left), 64'(0));
    chk_iline("stall", 64'h10);
    stall_at = -1;

    // Reset after four response beats, then a clean read
    i_got.delete(); mresp_k = 0;
    start_i(64'h600);
    for (int n = 0; n < 30 && i_got.size() < 4; n++) cycle("rst pre");
    rst_now = 1'b1;
    cycle("rst pulse");
    rst_now = 1'b0;
    chk("post rst ctl", 64'({i_reqack, i_respcyc, d_reqack, d_respcyc, m_reqcyc, m_respack, m_we}), 64'(0));
    chk("post rst m_req", m_req, 64'(0));
    i_got.delete(); mresp_k = 0; resp_base = 64'h30;
    start_i(64'h700);
    run_done("rst iread", 60);
    chk_iline("rst iread", 64'h30);

    // Random traffic
    rnd_data = 1'b1;
    p_new_i = 30; p_new_d = 30; p_dwe = 50; p_mack = 60; p_mresp = 60; p_iack = 70; p_dack = 70; p_rst = 1;
    repeat (3000) cycle("rand");
    p_new_i = 0; p_new_d = 0; p_rst = 0; p_mack = 100; p_mresp = 100; p_iack = 100; p_dack = 100;
    run_done("rand drain", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
